add_scheduler: RTL and testbench

ADD_SCHEDULER -- requirements
Module: add_scheduler

---
 rtl/add_scheduler.sv | 157 +++++++++++++++
 tb/tb_add_scheduler.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/add_scheduler.sv
// -----------------------------------------------------------------------------
// add_scheduler
//   Two requesters share one WIDTH-bit adder. Requests are granted round-robin,
//   operands are captured, the sum is registered one cycle later, and the
//   result is held until the consumer accepts it.
//
// Ports
//   clk                 : clock, rising edge
//   rst_n               : asynchronous active-low reset
//   req0_valid/req1_valid : requester operands valid
//   req0_a, req0_b      : requester 0 operands (WIDTH)
//   req1_a, req1_b      : requester 1 operands (WIDTH)
//   req0_ready/req1_ready : acceptance strobes (combinational, IDLE only)
//   rsp_valid           : result held
//   rsp_ready           : consumer accept
//   rsp_sum             : sum modulo 2^WIDTH
//   rsp_id              : originating requester
//   busy                : state is not IDLE
//   op_count            : completed response handshakes, wraps at 16 bits
// -----------------------------------------------------------------------------

// Plain combinational adder; carry out of the top bit is discarded.
module sixteenBitAdder #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o
);
  assign sum_o = a_i + b_i;
endmodule

module add_scheduler #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req0_ready,
  output logic             req1_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_id,
  output logic             busy,
  output logic [15:0]      op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             id_q, id_d;
  logic             last_q, last_d;     // requester granted most recently
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
  logic [15:0]      count_q, count_d;
  logic [WIDTH-1:0] add_sum;
  logic             grant_id;

  // The only adder: it sees the captured operands, never the live inputs.
  sixteenBitAdder #(.WIDTH(WIDTH)) u_adder (
    .a_i   (op_a_q),
    .b_i   (op_b_q),
    .sum_o (add_sum)
  );

  // Round-robin pick: a lone requester wins; on a tie the one not granted
  // last wins. Only meaningful when at least one valid is high.
  always_comb begin
    if (req0_valid && req1_valid) grant_id = ~last_q;
    else                          grant_id = req1_valid;
  end

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    id_d        = id_q;
    last_d      = last_q;
    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;
    count_d     = count_q;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;

    unique case (state_q)
      IDLE: begin
        req0_ready = req0_valid && (grant_id == 1'b0);
        req1_ready = req1_valid && (grant_id == 1'b1);
        if (req0_ready || req1_ready) begin
          op_a_d  = grant_id ? req1_a : req0_a;
          op_b_d  = grant_id ? req1_b : req0_b;
          id_d    = grant_id;
          last_d  = grant_id;
          state_d = EXEC;
        end
      end
      EXEC: begin
        rsp_sum_d   = add_sum;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          count_d     = count_q + 16'd1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_a_q      <= '0;
      op_b_q      <= '0;
      id_q        <= 1'b0;
      last_q      <= 1'b1;   // so requester 0 wins the first tie
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      count_q     <= 16'd0;
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      id_q        <= id_d;
      last_q      <= last_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      count_q     <= count_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_id    = id_q;
  assign busy      = (state_q != IDLE);
  assign op_count  = count_q;

endmodule

// File: tb/tb_add_scheduler.sv
// -----------------------------------------------------------------------------
// tb_add_scheduler
//   Directed bench for add_scheduler: single requests, wrap, backpressure,
//   operand hold, reset abort and round-robin alternation.
// -----------------------------------------------------------------------------
module tb_add_scheduler;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst_n;
  logic             req0_valid, req1_valid;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic             req0_ready, req1_ready;
  logic             rsp_valid, rsp_ready;
  logic [WIDTH-1:0] rsp_sum;
  logic             rsp_id;
  logic             busy;
  logic [15:0]      op_count;

  int n_cmp  = 0;
  int n_fail = 0;

  add_scheduler #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req0_ready (req0_ready),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_sum    (rsp_sum),
    .rsp_id     (rsp_id),
    .busy       (busy),
    .op_count   (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_a     = '0;
    req0_b     = '0;
    req1_a     = '0;
    req1_b     = '0;
    rsp_ready  = 1'b1;

    // Reset state
    step();
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_sum",   rsp_sum,   0);
    check("rst_rsp_id",    rsp_id,    0);
    check("rst_op_count",  op_count,  0);
    check("rst_busy",      busy,      0);
    rst_n = 1'b1;

    // req0 only, 4976 + 6789
    req0_valid = 1'b1; req0_a = 16'd4976; req0_b = 16'd6789;
    #1;
    check("t1_ready0", req0_ready, 1);
    check("t1_ready1", req1_ready, 0);
    step();                                   // accepting edge
    req0_valid = 1'b0;
    check("t1_busy_exec",  busy,      1);
    check("t1_valid_exec", rsp_valid, 0);
    step();                                   // EXEC -> RESP
    check("t1_rsp_valid", rsp_valid, 1);
    check("t1_rsp_sum",   rsp_sum,   16'h2DF5);
    check("t1_rsp_id",    rsp_id,    0);
    step();                                   // handshake
    check("t1_valid_done", rsp_valid, 0);
    check("t1_op_count",   op_count,  1);
    check("t1_busy_idle",  busy,      0);

    // req1 only, wrap: 0xFFFF + 2
    req1_valid = 1'b1; req1_a = 16'hFFFF; req1_b = 16'h0002;
    #1;
    check("t2_ready1", req1_ready, 1);
    check("t2_ready0", req0_ready, 0);
    step();
    req1_valid = 1'b0;
    step();
    check("t2_rsp_sum", rsp_sum, 16'h0001);
    check("t2_rsp_id",  rsp_id,  1);
    step();
    check("t2_op_count", op_count, 2);

    // Backpressure: 10 + 20 held for 5 cycles, req1 waiting meanwhile
    rsp_ready  = 1'b0;
    req0_valid = 1'b1; req0_a = 16'd10; req0_b = 16'd20;
    step();
    req0_valid = 1'b0;
    step();
    req1_valid = 1'b1; req1_a = 16'h1234; req1_b = 16'h1111;
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", rsp_valid,  1);
      check("bp_rsp_sum",   rsp_sum,    16'd30);
      check("bp_rsp_id",    rsp_id,     0);
      check("bp_ready0",    req0_ready, 0);
      check("bp_ready1",    req1_ready, 0);
      check("bp_op_count",  op_count,   2);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_still_valid", rsp_valid, 1);
    step();                                   // handshake
    check("bp_valid_done", rsp_valid,  0);
    check("bp_op_count3",  op_count,   3);
    check("bp_busy_idle",  busy,       0);
    check("bp_pending_r1", req1_ready, 1);
    // Withdraw before the edge: must not be accepted.
    req1_valid = 1'b0;
    #1;
    check("wd_ready1", req1_ready, 0);
    step();
    check("wd_busy", busy, 0);

    // Operand inputs change after acceptance
    req0_valid = 1'b1; req0_a = 16'd1; req0_b = 16'd1;
    step();
    req0_valid = 1'b0; req0_a = 16'h7777; req0_b = 16'h7777;
    step();
    check("hold_rsp_sum", rsp_sum, 16'd2);
    step();
    check("hold_op_count", op_count, 4);

    // Reset during EXEC aborts the operation
    req0_valid = 1'b1; req0_a = 16'd100; req0_b = 16'd200;
    step();
    req0_valid = 1'b0;
    check("ab_busy_exec", busy, 1);
    rst_n = 1'b0;
    #1;
    check("ab_busy",      busy,      0);
    check("ab_rsp_valid", rsp_valid, 0);
    check("ab_op_count",  op_count,  0);
    step();
    check("ab_rsp_valid2", rsp_valid, 0);
    check("ab_rsp_sum",    rsp_sum,   0);
    rst_n = 1'b1;

    // Both valid continuously: round-robin 0,1,0,1, 3 cycles apart
    req0_valid = 1'b1; req0_a = 16'd1;  req0_b = 16'd2;
    req1_valid = 1'b1; req1_a = 16'd10; req1_b = 16'd20;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr_ready0", req0_ready, (k % 2 == 0) ? 1 : 0);
      check("rr_ready1", req1_ready, (k % 2 == 1) ? 1 : 0);
      step();                                 // accept
      check("rr_valid_exec", rsp_valid, 0);
      step();                                 // EXEC -> RESP
      check("rr_rsp_valid", rsp_valid, 1);
      check("rr_rsp_id",    rsp_id,    k % 2);
      check("rr_rsp_sum",   rsp_sum,   (k % 2 == 0) ? 3 : 30);
      step();                                 // handshake
      check("rr_op_count",  op_count,  k + 1);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    check("rr_final_count", op_count, 4);
    check("rr_final_busy",  busy,     0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
